led_channel_scanner: RTL

Registered, parametrised N-bit by CHANNELS-way channel selector driving the LED bank. Successor to the combinational 2:1 LED mux. Two modes:
- **Manual:** the channel is picked by `i_sel`.
- **Auto:** the block scans through all channels, dwelling DWELL clocks on each. Freeze and single-step controls support bring-up.

It sits between the per-channel status sources and the LED pins, giving one clean registered LED word per clock.

---
 rtl/led_channel_scanner_if.sv | 23 ++
 rtl/led_channel_scanner.sv | 58 +++++
 2 files changed

// File: rtl/led_channel_scanner_if.sv
// led_channel_scanner_if: channel data, mode controls and LED outputs of the scanner
interface led_channel_scanner_if #(
  parameter int N = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
);
  logic [CHANNELS*N-1:0] i_ch_data;
  logic i_mode;
  logic [SEL_W-1:0] i_sel;
  logic i_freeze;
  logic i_step;
  logic [N-1:0] o_y;
  logic [SEL_W-1:0] o_ch;
  logic o_wrap;
  modport master (
    output i_ch_data, i_mode, i_sel, i_freeze, i_step,
    input o_y, o_ch, o_wrap
  );
  modport slave (
    input i_ch_data, i_mode, i_sel, i_freeze, i_step,
    output o_y, o_ch, o_wrap
  );
endinterface

// File: rtl/led_channel_scanner.sv
// led_channel_scanner: registered manual/auto-scan channel selector driving the LED bank
module led_channel_scanner #(
  parameter int N = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL = 4
) (
  input logic i_clk,
  input logic i_rst_n,
  led_channel_scanner_if.slave bus
);
  localparam int SEL_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CHANNELS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(DWELL - 1);
  typedef enum logic [1:0] {MANUAL, AUTO_RUN, AUTO_HOLD} state_t;
  state_t r_state;
  logic [CW-1:0] r_c;
  logic [SEL_W-1:0] r_ch;
  logic [N-1:0] r_y;
  logic r_wrap;
  logic [N-1:0] w_ch_data [CHANNELS];
  logic w_auto;
  logic w_adv;
  logic w_sel_ok;
  logic [SEL_W-1:0] w_ch_inc;
  logic [SEL_W-1:0] w_next_ch;
  logic [CW-1:0] w_next_c;
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign w_ch_data[g] = bus.i_ch_data[g*N +: N];
  end
  // Behaviour on each edge follows the state registered on the previous edge
  assign w_auto = r_state != MANUAL;
  assign w_adv = w_auto && (bus.i_step || (r_state == AUTO_RUN && r_c == C_LAST));
  assign w_ch_inc = r_ch == CH_LAST ? '0 : r_ch + 1'b1;
  assign w_sel_ok = {1'b0, bus.i_sel} < (SEL_W + 1)'(CHANNELS);
  always_comb begin
    w_next_ch = !w_auto ? (w_sel_ok ? bus.i_sel : r_ch) : (w_adv ? w_ch_inc : r_ch);
    w_next_c = (!w_auto || w_adv) ? '0 : (r_state == AUTO_RUN ? r_c + 1'b1 : r_c);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= MANUAL;
      r_c <= '0;
      r_ch <= '0;
      r_y <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_state <= !bus.i_mode ? MANUAL : (bus.i_freeze ? AUTO_HOLD : AUTO_RUN);
      r_c <= w_next_c;
      r_ch <= w_next_ch;
      r_y <= w_ch_data[w_next_ch];
      r_wrap <= w_adv && r_ch == CH_LAST;
    end
  end
  assign bus.o_y = r_y;
  assign bus.o_ch = r_ch;
  assign bus.o_wrap = r_wrap;
endmodule
